// File: rtl/ttl_parity_accumulator.sv
// Multi-lane frame parity generator/checker: each lane XOR-reduces its word every
// enabled clock, accumulates over FRAME_LEN words and registers 74280-style sums.
module ttl_parity_accumulator #(
  parameter int BLOCKS     = 4,
  parameter int WIDTH_IN   = 2,
  parameter int FRAME_LEN  = 4,
  parameter int CNT_WIDTH  = 2,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic                         Clk,
  input  logic                         Clear,
  input  logic                         Enable,
  input  logic [BLOCKS*WIDTH_IN-1:0]   A_2D,
  input  logic [BLOCKS-1:0]            P_expected,
  output logic [BLOCKS-1:0]            Sum_even,
  output logic [BLOCKS-1:0]            Sum_odd,
  output logic [BLOCKS-1:0]            Error,
  output logic                         Done,
  output logic [CNT_WIDTH-1:0]         Count
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(FRAME_LEN - 1);
  localparam int OUT_W = 3*BLOCKS + 1 + CNT_WIDTH;

  // Handshake: Enable is a valid-only strobe with no back-pressure; every edge with
  // Enable=1 and Clear=0 consumes A_2D, and P_expected is only used on the edge that
  // accepts the last word of a frame.

  logic [BLOCKS-1:0]    r_acc;
  logic [CNT_WIDTH-1:0] r_count;
  logic [BLOCKS-1:0]    r_sum_even;
  logic [BLOCKS-1:0]    r_sum_odd;
  logic [BLOCKS-1:0]    r_err;
  logic                 r_done;

  logic [BLOCKS-1:0]    w_wp;
  logic [BLOCKS-1:0]    w_frame;
  logic                 w_last;

  always_comb begin
    w_wp = '0;
    for (int b = 0; b < BLOCKS; b++) begin
      w_wp[b] = ^A_2D[b*WIDTH_IN +: WIDTH_IN];
    end
  end

  assign w_frame = r_acc ^ w_wp;
  assign w_last  = (r_count == LAST_CNT);

  always_ff @(posedge Clk) begin
    if (Clear) begin
      r_acc      <= '0;
      r_count    <= '0;
      r_done     <= 1'b0;
      r_err      <= '0;
      r_sum_even <= '1;
      r_sum_odd  <= '0;
    end else begin
      r_done <= 1'b0;
      if (Enable) begin
        if (w_last) begin
          r_sum_odd  <= w_frame;
          r_sum_even <= ~w_frame;
          r_err      <= r_err | (w_frame ^ P_expected);
          r_done     <= 1'b1;
          r_acc      <= '0;
          r_count    <= '0;
        end else begin
          r_acc   <= w_frame;
          r_count <= r_count + CNT_WIDTH'(1);
        end
      end
    end
  end

  // Separate rise and fall delays: delay the register image by each amount, then a
  // bit follows the slower copy on the edge direction that should lag.
  logic [OUT_W-1:0] w_out_reg;
  logic [OUT_W-1:0] w_dly_r;
  logic [OUT_W-1:0] w_dly_f;
  logic [OUT_W-1:0] w_out;

  assign w_out_reg = {r_sum_even, r_sum_odd, r_err, r_done, r_count};
  assign #(DELAY_RISE) w_dly_r = w_out_reg;
  assign #(DELAY_FALL) w_dly_f = w_out_reg;

  generate
    if (DELAY_RISE >= DELAY_FALL) begin : g_rise_slow
      assign w_out = w_dly_r & w_dly_f;
    end else begin : g_fall_slow
      assign w_out = w_dly_r | w_dly_f;
    end
  endgenerate

  assign {Sum_even, Sum_odd, Error, Done, Count} = w_out;

endmodule

// File: tb/tb_ttl_parity_accumulator.sv
// Directed bench for ttl_parity_accumulator: vector table for frame behaviour,
// hand sequences for output timing and unknown-bit propagation.
module tb_ttl_parity_accumulator;

  localparam int BLOCKS = 5;
  localparam int WIDTH_IN = 3;
  localparam int FRAME_LEN = 4;
  localparam int CNT_WIDTH = 2;

  logic                       Clk;
  logic                       Clear;
  logic                       Enable;
  logic [BLOCKS*WIDTH_IN-1:0] A_2D;
  logic [BLOCKS-1:0]          P_expected;
  logic [BLOCKS-1:0]          Sum_even;
  logic [BLOCKS-1:0]          Sum_odd;
  logic [BLOCKS-1:0]          Error;
  logic                       Done;
  logic [CNT_WIDTH-1:0]       Count;

  int n_tests = 0;
  int n_fail  = 0;

  ttl_parity_accumulator #(
    .BLOCKS(BLOCKS), .WIDTH_IN(WIDTH_IN), .FRAME_LEN(FRAME_LEN),
    .CNT_WIDTH(CNT_WIDTH), .DELAY_RISE(5), .DELAY_FALL(3)
  ) dut (
    .Clk(Clk), .Clear(Clear), .Enable(Enable), .A_2D(A_2D),
    .P_expected(P_expected), .Sum_even(Sum_even), .Sum_odd(Sum_odd),
    .Error(Error), .Done(Done), .Count(Count)
  );

  // clock / watchdog
  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  initial begin
    #90000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string                      name;
    logic                       clr;
    logic                       en;
    logic [BLOCKS*WIDTH_IN-1:0] a;
    logic [BLOCKS-1:0]          p;
    logic [BLOCKS-1:0]          exp_even;
    logic [BLOCKS-1:0]          exp_odd;
    logic [BLOCKS-1:0]          exp_err;
    logic                       exp_done;
    logic [CNT_WIDTH-1:0]       exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic clr, input logic en,
                     input logic [14:0] a, input logic [4:0] p,
                     input logic [4:0] ev, input logic [4:0] od, input logic [4:0] er,
                     input logic dn, input logic [1:0] cn);
    vec_t v;
    v.name = name; v.clr = clr; v.en = en; v.a = a; v.p = p;
    v.exp_even = ev; v.exp_odd = od; v.exp_err = er; v.exp_done = dn; v.exp_cnt = cn;
    vecs.push_back(v);
  endtask

  // driver: apply inputs, take one edge, return at the following falling edge
  task automatic step(input logic clr, input logic en, input logic [14:0] a,
                      input logic [4:0] p);
    Clear = clr; Enable = en; A_2D = a; P_expected = p;
    @(posedge Clk);
    #10;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [17:0] act_v;
  logic [17:0] exp_v;
  logic        probe_x;

  initial begin
    Clear = 1'b0; Enable = 1'b0; A_2D = '0; P_expected = '0;

    // name, clr, en, a, p, even, odd, err, done, cnt
    add("clear",      1, 0, 15'h0000, 5'h00, 5'h1F, 5'h00, 5'h00, 0, 2'd0);
    add("t2_w1",      0, 1, 15'h0001, 5'h00, 5'h1F, 5'h00, 5'h00, 0, 2'd1);
    add("t2_w2",      0, 1, 15'h0001, 5'h00, 5'h1F, 5'h00, 5'h00, 0, 2'd2);
    add("t2_w3",      0, 1, 15'h0001, 5'h00, 5'h1F, 5'h00, 5'h00, 0, 2'd3);
    add("t2_w4",      0, 1, 15'h0001, 5'h00, 5'h1F, 5'h00, 5'h00, 1, 2'd0);
    add("t2_idle",    0, 0, 15'h0000, 5'h00, 5'h1F, 5'h00, 5'h00, 0, 2'd0);
    add("t3_w1",      0, 1, 15'h01C0, 5'h00, 5'h1F, 5'h00, 5'h00, 0, 2'd1);
    add("t3_w2",      0, 1, 15'h0000, 5'h00, 5'h1F, 5'h00, 5'h00, 0, 2'd2);
    add("t3_w3",      0, 1, 15'h0000, 5'h00, 5'h1F, 5'h00, 5'h00, 0, 2'd3);
    add("t3_w4",      0, 1, 15'h0000, 5'h00, 5'h1B, 5'h04, 5'h04, 1, 2'd0);
    add("t3b_w1",     0, 1, 15'h0000, 5'h00, 5'h1B, 5'h04, 5'h04, 0, 2'd1);
    add("t3b_w2",     0, 1, 15'h0000, 5'h00, 5'h1B, 5'h04, 5'h04, 0, 2'd2);
    add("t3b_w3",     0, 1, 15'h0000, 5'h00, 5'h1B, 5'h04, 5'h04, 0, 2'd3);
    add("t3b_w4",     0, 1, 15'h0000, 5'h00, 5'h1F, 5'h00, 5'h04, 1, 2'd0);
    add("t4_e1",      0, 1, 15'h0010, 5'h02, 5'h1F, 5'h00, 5'h04, 0, 2'd1);
    add("t4_e2",      0, 1, 15'h0000, 5'h02, 5'h1F, 5'h00, 5'h04, 0, 2'd2);
    add("t4_hold1",   0, 0, 15'h0201, 5'h02, 5'h1F, 5'h00, 5'h04, 0, 2'd2);
    add("t4_hold2",   0, 0, 15'h0201, 5'h02, 5'h1F, 5'h00, 5'h04, 0, 2'd2);
    add("t4_hold3",   0, 0, 15'h0201, 5'h02, 5'h1F, 5'h00, 5'h04, 0, 2'd2);
    add("t4_e3",      0, 1, 15'h0010, 5'h02, 5'h1F, 5'h00, 5'h04, 0, 2'd3);
    add("t4_e4",      0, 1, 15'h0010, 5'h02, 5'h1D, 5'h02, 5'h04, 1, 2'd0);
    add("t5_w1",      0, 1, 15'h0001, 5'h00, 5'h1D, 5'h02, 5'h04, 0, 2'd1);
    add("t5_w2",      0, 1, 15'h0000, 5'h00, 5'h1D, 5'h02, 5'h04, 0, 2'd2);
    add("t5_clr_en",  1, 1, 15'h0001, 5'h00, 5'h1F, 5'h00, 5'h00, 0, 2'd0);
    add("t5b_w1",     0, 1, 15'h4000, 5'h10, 5'h1F, 5'h00, 5'h00, 0, 2'd1);
    add("t5b_w2",     0, 1, 15'h0000, 5'h10, 5'h1F, 5'h00, 5'h00, 0, 2'd2);
    add("t5b_w3",     0, 1, 15'h0000, 5'h10, 5'h1F, 5'h00, 5'h00, 0, 2'd3);
    add("t5b_w4",     0, 1, 15'h0000, 5'h10, 5'h0F, 5'h10, 5'h00, 1, 2'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].clr, vecs[i].en, vecs[i].a, vecs[i].p);
      act_v = {Sum_even, Sum_odd, Error, Done, Count};
      exp_v = {vecs[i].exp_even, vecs[i].exp_odd, vecs[i].exp_err,
               vecs[i].exp_done, vecs[i].exp_cnt};
      check(vecs[i].name, 32'(act_v), 32'(exp_v));
    end

    // output timing around a frame-completing edge (rise 5, fall 3)
    step(0, 1, 15'h0000, 5'h00);
    step(0, 1, 15'h0000, 5'h00);
    step(0, 1, 15'h0000, 5'h00);
    Enable = 1'b1;
    @(posedge Clk);
    #2;
    check("done_not_yet_risen", 32'(Done === 1'b1), 32'd0);
    #4;
    check("done_risen_at_6", 32'(Done), 32'd1);
    Enable = 1'b0;
    @(posedge Clk);
    #2;
    check("done_still_high_at_2", 32'(Done), 32'd1);
    #2;
    check("done_fallen_at_4", 32'(Done), 32'd0);
    #6;

    // unknown bit in lane1 word; lane2 carries a real odd word
    probe_x = 1'bx;
    step(0, 1, 15'b000_000_001_0x1_000, 5'h04);
    step(0, 1, 15'h0000, 5'h04);
    step(0, 1, 15'h0000, 5'h04);
    step(0, 1, 15'h0000, 5'h04);
    check("x_other_lanes_odd", 32'(Sum_odd & 5'b11101), 32'h04);
    check("x_other_lanes_even", 32'(Sum_even & 5'b11101), 32'h19);
    check("x_other_lanes_err", 32'(Error & 5'b11101), 32'h00);
    check("x_done", 32'(Done), 32'd1);
    if ($isunknown(probe_x)) begin
      check("x_lane1_odd_unknown", 32'($isunknown(Sum_odd[1])), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
